// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, FSM states and bus widths.
package sdram_pkg;
  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ} state_t;
endpackage

// File: rtl/sdram_arbit_wdog.sv
// sdram_arbit_wdog: saturating watchdog counter that flags an operation overstaying TIMEOUT cycles.
module sdram_arbit_wdog #(
  parameter logic [9:0] TIMEOUT = 10'd1000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);
  logic [9:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (run_i && cnt_q != TIMEOUT - 10'd1) ? cnt_q + 10'd1 : cnt_q;
  assign expire_o = run_i && cnt_q == TIMEOUT - 10'd1;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: init sequencing and fixed-priority/round-robin sharing of the SDRAM command bus
// between refresh, write and read sub-controllers, with a watchdog recovering stuck operations.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [9:0] TIMEOUT = 10'd1000,
  parameter logic [3:0] NOP     = CMD_NOP
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              flag_ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [BANK_W-1:0] ref_bank,
  input  logic              wr_req,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              rd_req,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic              flag_init_done,
  output logic              err_timeout
);
  state_t state_q, state_d;
  logic ref_en_q, wr_en_q, rd_en_q, ref_en_d, wr_en_d, rd_en_d;
  logic last_q, last_d, done_q, done_d, err_q, err_d;
  logic active, end_act, expire;
  sdram_arbit_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i   (sclk),
    .rst_n_i (s_rst_n),
    .clr_i   (state_q == S_ARBIT),
    .run_i   (active),
    .expire_o(expire)
  );
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      state_q  <= S_IDLE;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_en_q <= ref_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  // last_q: 1 = write was granted most recently, 0 = read
  always_comb begin
    active  = state_q == S_AREF || state_q == S_WRITE || state_q == S_READ;
    end_act = (state_q == S_AREF && flag_ref_end) || (state_q == S_WRITE && flag_wr_end) ||
              (state_q == S_READ && flag_rd_end);
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_INIT;
      S_INIT:  state_d = flag_init_end ? S_ARBIT : S_INIT;
      S_ARBIT: state_d = ref_req ? S_AREF : (wr_req && rd_req) ? (last_q ? S_READ : S_WRITE) :
                         wr_req ? S_WRITE : rd_req ? S_READ : S_ARBIT;
      S_AREF, S_WRITE, S_READ: state_d = (end_act || expire) ? S_ARBIT : state_q;
      default: state_d = S_IDLE;
    endcase
    ref_en_d = state_q == S_ARBIT && state_d == S_AREF;
    wr_en_d  = state_q == S_ARBIT && state_d == S_WRITE;
    rd_en_d  = state_q == S_ARBIT && state_d == S_READ;
    last_d   = wr_en_d ? 1'b1 : rd_en_d ? 1'b0 : last_q;
    done_d   = done_q || (state_q == S_INIT && flag_init_end);
    err_d    = err_q || (expire && !end_act);
  end
  always_comb begin
    sdram_cmd  = state_q == S_INIT ? init_cmd : state_q == S_AREF ? ref_cmd :
                 state_q == S_WRITE ? wr_cmd : state_q == S_READ ? rd_cmd : NOP;
    sdram_addr = state_q == S_INIT ? init_addr : state_q == S_AREF ? ref_addr :
                 state_q == S_WRITE ? wr_addr : state_q == S_READ ? rd_addr : '0;
    sdram_bank = state_q == S_AREF ? ref_bank : state_q == S_WRITE ? wr_bank :
                 state_q == S_READ ? rd_bank : '0;
  end
  assign ref_en         = ref_en_q;
  assign wr_en          = wr_en_q;
  assign rd_en          = rd_en_q;
  assign sdram_cke      = 1'b1;
  assign flag_init_done = done_q;
  assign err_timeout    = err_q;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed cycle-by-cycle checks of init, arbitration, grants, watchdog and reset.
module tb_sdram_arbit;
  localparam logic [3:0] NOPC = 4'b0111;
  localparam logic [3:0] ICMD = 4'b0000, RCMD = 4'b0001, WCMD = 4'b0100, DCMD = 4'b0101;
  localparam logic [11:0] IADR = 12'h123, RADR = 12'h0AA, WADR = 12'h0B0, DADR = 12'h0C0;
  logic sclk = 0, s_rst_n = 0;
  logic flag_init_end = 0, ref_req = 0, flag_ref_end = 0, wr_req = 0, flag_wr_end = 0;
  logic rd_req = 0, flag_rd_end = 0;
  logic ref_en, wr_en, rd_en, sdram_cke, flag_init_done, err_timeout;
  logic [3:0] sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0] sdram_bank;
  int n_chk = 0, n_err = 0;
  always #5 sclk = ~sclk;
  sdram_arbit #(.TIMEOUT(10'd16)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end), .init_cmd(ICMD), .init_addr(IADR),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(RCMD), .ref_addr(RADR), .ref_bank(2'd1),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(WCMD), .wr_addr(WADR), .wr_bank(2'd2),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(DCMD), .rd_addr(DADR), .rd_bank(2'd3),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd),
    .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .flag_init_done(flag_init_done),
    .err_timeout(err_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge sclk);
  endtask
  initial begin
    logic exp_w;
    int n;
    step;
    chk("rst_en", {ref_en, wr_en, rd_en}, 3'b000);
    chk("rst_cmd", sdram_cmd, NOPC);
    chk("rst_addr", {sdram_addr, sdram_bank}, 14'h0);
    chk("rst_flags", {flag_init_done, err_timeout, sdram_cke}, 3'b001);
    s_rst_n = 1;
    step;
    chk("init_cmd", sdram_cmd, ICMD);
    chk("init_bus", {sdram_addr, sdram_bank}, {IADR, 2'd0});
    repeat (198) step;
    chk("init_hold", sdram_cmd, ICMD);
    chk("init_done_early", flag_init_done, 1'b0);
    flag_init_end = 1;
    step;
    flag_init_end = 0;
    chk("arb_nop", sdram_cmd, NOPC);
    chk("init_done", flag_init_done, 1'b1);
    wr_req = 1;
    rd_req = 1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(wr_en || rd_en || ref_en) && n < 20) begin
        step;
        n++;
      end
      chk("rr_grant_seen", n < 20, 1'b1);
      exp_w = (g % 2) == 0;
      chk("rr_wr_en", wr_en, exp_w);
      chk("rr_rd_en", rd_en, !exp_w);
      chk("rr_cmd", sdram_cmd, exp_w ? WCMD : DCMD);
      repeat (8) step;
      chk("rr_busy", sdram_cmd, exp_w ? WCMD : DCMD);
      if (exp_w) flag_wr_end = 1; else flag_rd_end = 1;
      step;
      flag_wr_end = 0;
      flag_rd_end = 0;
      chk("rr_gap_nop", sdram_cmd, NOPC);
    end
    wr_req = 0;
    rd_req = 0;
    ref_req = 1;
    wr_req = 1;
    step;
    chk("ref_en", {ref_en, wr_en, rd_en}, 3'b100);
    chk("ref_bus", {sdram_cmd, sdram_addr, sdram_bank}, {RCMD, RADR, 2'd1});
    ref_req = 0;
    step;
    chk("ref_en_1cyc", ref_en, 1'b0);
    flag_ref_end = 1;
    step;
    flag_ref_end = 0;
    chk("ref_gap_nop", sdram_cmd, NOPC);
    chk("ref_gap_en", {ref_en, wr_en, rd_en}, 3'b000);
    step;
    chk("wr_after_ref", {ref_en, wr_en, rd_en}, 3'b010);
    chk("wr_bus", {sdram_cmd, sdram_addr, sdram_bank}, {WCMD, WADR, 2'd2});
    wr_req = 0;
    rd_req = 1;
    flag_rd_end = 1;
    step;
    flag_rd_end = 0;
    chk("ign_rd_end", sdram_cmd, WCMD);
    chk("ign_rd_en", rd_en, 1'b0);
    step;
    chk("ign_stay", sdram_cmd, WCMD);
    flag_wr_end = 1;
    step;
    flag_wr_end = 0;
    chk("wr_end_nop", sdram_cmd, NOPC);
    step;
    chk("rd_grant", {ref_en, wr_en, rd_en}, 3'b001);
    chk("rd_bus", {sdram_cmd, sdram_addr, sdram_bank}, {DCMD, DADR, 2'd3});
    rd_req = 0;
    repeat (15) step;
    chk("wd_before", {sdram_cmd, err_timeout}, {DCMD, 1'b0});
    step;
    chk("wd_expired", {sdram_cmd, err_timeout}, {NOPC, 1'b1});
    repeat (3) step;
    chk("wd_sticky", err_timeout, 1'b1);
    ref_req = 1;
    step;
    chk("ref2_en", ref_en, 1'b1);
    ref_req = 0;
    s_rst_n = 0;
    #1;
    chk("arst_en", {ref_en, wr_en, rd_en}, 3'b000);
    chk("arst_cmd", sdram_cmd, NOPC);
    chk("arst_flags", {flag_init_done, err_timeout}, 2'b00);
    step;
    s_rst_n = 1;
    step;
    chk("reinit_cmd", sdram_cmd, ICMD);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
